// File: rtl/gmii_frame_generator_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : gmii_frame_generator_if
// Description : 8-bit GMII transmit bus (data, enable, error).
// Revision    : 1.0 - initial release
// ============================================================================
interface gmii_frame_generator_if;
    logic [7:0] gmii_d;
    logic       gmii_en;
    logic       gmii_er;

    modport master (
        output gmii_d,
        output gmii_en,
        output gmii_er
    );

    modport slave (
        input gmii_d,
        input gmii_en,
        input gmii_er
    );
endinterface
`default_nettype wire

// File: rtl/gmii_frame_generator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : gmii_frame_generator
// Description : GMII TX frame generator (preamble, SFD, header, incrementing
//               payload, CRC-32 FCS, IFG) with packet/octet counters.
//               Optional FCS corruption: GMII_FRAME_GENERATOR_CRC_ERR_INJECT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module gmii_frame_generator #(
    parameter int C_MAX_FRAME_LEN = 1518,
    parameter int C_COUNTER_WIDTH = 64
) (
    input  wire logic                        clk,
    input  wire logic                        reset,
    input  wire logic                        start,
    input  wire logic                        stop,
    input  wire logic [15:0]                 frame_len,
    input  wire logic [15:0]                 ifg_len,
    input  wire logic [31:0]                 frame_count,
    input  wire logic [47:0]                 dst_mac,
    input  wire logic [47:0]                 src_mac,
    input  wire logic [15:0]                 ethertype,
    input  wire logic [7:0]                  payload_seed,
    input  wire logic                        inject_crc_err,
    gmii_frame_generator_if.master           gmii,
    output logic                             busy,
    output logic [C_COUNTER_WIDTH-1:0]       pkts_sent,
    output logic [C_COUNTER_WIDTH-1:0]       octets_sent
);

    localparam logic [15:0] C_MIN_LEN      = 16'd64;
    localparam logic [15:0] C_MAX_LEN      = 16'(C_MAX_FRAME_LEN);
    localparam logic [15:0] C_MIN_IFG      = 16'd12;
    localparam logic [15:0] C_PREAMBLE_END = 16'd6;
    localparam logic [15:0] C_HDR_OCTETS   = 16'd14;
    localparam logic [31:0] C_CRC_INIT     = 32'hFFFF_FFFF;
    localparam logic [31:0] C_CRC_POLY     = 32'hEDB8_8320;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_SFD      = 3'd2,
        S_DATA     = 3'd3,
        S_FCS      = 3'd4,
        S_IFG      = 3'd5
    } state_t;

    state_t                     state_q, state_d;
    logic [15:0]                cnt_q, cnt_d;
    logic [15:0]                len_q, len_d;
    logic [15:0]                ifg_q, ifg_d;
    logic [31:0]                fc_q, fc_d;
    logic [31:0]                frames_q, frames_d;
    logic [111:0]               hdr_cfg_q, hdr_cfg_d;
    logic [111:0]               hdr_sh_q, hdr_sh_d;
    logic [7:0]                 seed_q, seed_d;
    logic [7:0]                 pay_q, pay_d;
    logic                       stop_pend_q, stop_pend_d;
    logic [31:0]                crc_q, crc_d;
    logic [7:0]                 d_q, d_d;
    logic                       en_q, en_d;
    logic                       busy_q, busy_d;
    logic [C_COUNTER_WIDTH-1:0] pkts_q, pkts_d;
    logic [C_COUNTER_WIDTH-1:0] octets_q, octets_d;

    logic [7:0]                 w_data_octet;
    logic [31:0]                w_fcs;
    logic [7:0]                 w_fcs_octet;
    logic [7:0]                 w_fcs_flip;

    // Reflected CRC-32, one octet consumed LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ C_CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

`ifdef GMII_FRAME_GENERATOR_CRC_ERR_INJECT_EN
    logic inj_q, inj_d;
    assign w_fcs_flip = {7'b0, inj_q & (cnt_q == 16'd0)};
`else
    logic w_unused_inject;
    assign w_unused_inject = inject_crc_err;
    assign w_fcs_flip      = 8'h00;
`endif

    assign w_data_octet = (cnt_q < C_HDR_OCTETS) ? hdr_sh_q[111:104] : pay_q;
    assign w_fcs        = ~crc_q;

    always_comb begin
        w_fcs_octet = w_fcs[7:0];
        case (cnt_q[1:0])
            2'd0:    w_fcs_octet = w_fcs[7:0];
            2'd1:    w_fcs_octet = w_fcs[15:8];
            2'd2:    w_fcs_octet = w_fcs[23:16];
            default: w_fcs_octet = w_fcs[31:24];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        ifg_d       = ifg_q;
        fc_d        = fc_q;
        frames_d    = frames_q;
        hdr_cfg_d   = hdr_cfg_q;
        hdr_sh_d    = hdr_sh_q;
        seed_d      = seed_q;
        pay_d       = pay_q;
        stop_pend_d = stop_pend_q;
        crc_d       = crc_q;
        d_d         = 8'h00;
        en_d        = 1'b0;
        busy_d      = busy_q;
        pkts_d      = pkts_q;
        octets_d    = octets_q;
`ifdef GMII_FRAME_GENERATOR_CRC_ERR_INJECT_EN
        inj_d       = inj_q;
`endif

        // A stop at any point of an active burst is held until the IFG ends.
        if (state_q != S_IDLE && stop) begin
            stop_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d     = S_PREAMBLE;
                    cnt_d       = 16'd0;
                    busy_d      = 1'b1;
                    frames_d    = 32'd0;
                    stop_pend_d = 1'b0;
                    fc_d        = frame_count;
                    hdr_cfg_d   = {dst_mac, src_mac, ethertype};
                    seed_d      = payload_seed;
                    if (frame_len < C_MIN_LEN)      len_d = C_MIN_LEN;
                    else if (frame_len > C_MAX_LEN) len_d = C_MAX_LEN;
                    else                            len_d = frame_len;
                    ifg_d = (ifg_len < C_MIN_IFG) ? C_MIN_IFG : ifg_len;
                end
            end

            S_PREAMBLE: begin
                d_d  = 8'h55;
                en_d = 1'b1;
`ifdef GMII_FRAME_GENERATOR_CRC_ERR_INJECT_EN
                if (cnt_q == 16'd0) inj_d = inject_crc_err;
`endif
                if (cnt_q == C_PREAMBLE_END) begin
                    state_d = S_SFD;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_SFD: begin
                d_d      = 8'hD5;
                en_d     = 1'b1;
                crc_d    = C_CRC_INIT;
                hdr_sh_d = hdr_cfg_q;
                pay_d    = seed_q;
                state_d  = S_DATA;
                cnt_d    = 16'd0;
            end

            S_DATA: begin
                d_d   = w_data_octet;
                en_d  = 1'b1;
                crc_d = crc_byte(crc_q, w_data_octet);
                if (cnt_q < C_HDR_OCTETS) hdr_sh_d = {hdr_sh_q[103:0], 8'h00};
                else                      pay_d    = pay_q + 8'd1;
                if (cnt_q == len_q - 16'd5) begin
                    state_d = S_FCS;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_FCS: begin
                d_d  = w_fcs_octet ^ w_fcs_flip;
                en_d = 1'b1;
                if (cnt_q == 16'd3) begin
                    pkts_d   = pkts_q + 1'b1;
                    octets_d = octets_q + {{(C_COUNTER_WIDTH-16){1'b0}}, len_q};
                    frames_d = frames_q + 32'd1;
                    state_d  = S_IFG;
                    cnt_d    = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_IFG: begin
                if (cnt_q == ifg_q - 16'd1) begin
                    cnt_d = 16'd0;
                    if ((fc_q != 32'd0 && frames_q == fc_q) || stop_pend_q || stop) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_PREAMBLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            len_q       <= 16'd0;
            ifg_q       <= 16'd0;
            fc_q        <= 32'd0;
            frames_q    <= 32'd0;
            hdr_cfg_q   <= 112'd0;
            hdr_sh_q    <= 112'd0;
            seed_q      <= 8'h00;
            pay_q       <= 8'h00;
            stop_pend_q <= 1'b0;
            crc_q       <= C_CRC_INIT;
            d_q         <= 8'h00;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            pkts_q      <= '0;
            octets_q    <= '0;
`ifdef GMII_FRAME_GENERATOR_CRC_ERR_INJECT_EN
            inj_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            ifg_q       <= ifg_d;
            fc_q        <= fc_d;
            frames_q    <= frames_d;
            hdr_cfg_q   <= hdr_cfg_d;
            hdr_sh_q    <= hdr_sh_d;
            seed_q      <= seed_d;
            pay_q       <= pay_d;
            stop_pend_q <= stop_pend_d;
            crc_q       <= crc_d;
            d_q         <= d_d;
            en_q        <= en_d;
            busy_q      <= busy_d;
            pkts_q      <= pkts_d;
            octets_q    <= octets_d;
`ifdef GMII_FRAME_GENERATOR_CRC_ERR_INJECT_EN
            inj_q       <= inj_d;
`endif
        end
    end

    assign gmii.gmii_d  = d_q;
    assign gmii.gmii_en = en_q;
    assign gmii.gmii_er = 1'b0;
    assign busy         = busy_q;
    assign pkts_sent    = pkts_q;
    assign octets_sent  = octets_q;

endmodule
`default_nettype wire

// File: tb/tb_gmii_frame_generator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_gmii_frame_generator
// Description : Scoreboard bench for gmii_frame_generator; expected frames are
//               built from an octet-list model and checked by a GMII monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gmii_frame_generator;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, stop;
    logic [15:0] frame_len, ifg_len;
    logic [31:0] frame_count;
    logic [47:0] dst_mac, src_mac;
    logic [15:0] ethertype;
    logic [7:0]  payload_seed;
    logic        inject_crc_err;
    logic        busy;
    logic [63:0] pkts_sent, octets_sent;

    gmii_frame_generator_if gif();

    gmii_frame_generator #(.C_MAX_FRAME_LEN(1518), .C_COUNTER_WIDTH(64)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .frame_len(frame_len), .ifg_len(ifg_len), .frame_count(frame_count),
        .dst_mac(dst_mac), .src_mac(src_mac), .ethertype(ethertype),
        .payload_seed(payload_seed), .inject_crc_err(inject_crc_err),
        .gmii(gif), .busy(busy), .pkts_sent(pkts_sent), .octets_sent(octets_sent)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_bytes[$];
    int          exp_len[$];
    int          exp_gap[$];
    logic [63:0] exp_pkts = 64'd0;
    logic [63:0] exp_octets = 64'd0;
    logic [47:0] cfg_dmac, cfg_smac;
    logic [15:0] cfg_etype;
    logic [7:0]  cfg_seed;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Standard Ethernet FCS computed over a byte list.
    function automatic logic [31:0] eth_crc32(input logic [7:0] data[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (data[k]) begin
            for (int b = 0; b < 8; b++) begin
                if ((c[0] ^ data[k][b]) == 1'b1) c = (c >> 1) ^ 32'hEDB8_8320;
                else                             c = c >> 1;
            end
        end
        return ~c;
    endfunction

    task automatic push_frame(input int len, input int ifg, input bit first, input bit inj);
        int          lc, ic;
        logic [7:0]  data[$];
        logic [31:0] fcs;
        logic [47:0] t48;
        logic [15:0] t16;
        lc = (len < 64) ? 64 : ((len > 1518) ? 1518 : len);
        ic = (ifg < 12) ? 12 : ifg;
        for (int i = 0; i < lc - 4; i++) begin
            if (i < 6) begin
                t48 = cfg_dmac >> (8 * (5 - i));
                data.push_back(t48[7:0]);
            end else if (i < 12) begin
                t48 = cfg_smac >> (8 * (11 - i));
                data.push_back(t48[7:0]);
            end else if (i < 14) begin
                t16 = cfg_etype >> (8 * (13 - i));
                data.push_back(t16[7:0]);
            end else begin
                data.push_back(8'((int'(cfg_seed) + i - 14) % 256));
            end
        end
        fcs = eth_crc32(data);
        for (int i = 0; i < 7; i++) exp_bytes.push_back(8'h55);
        exp_bytes.push_back(8'hD5);
        foreach (data[k]) exp_bytes.push_back(data[k]);
        exp_bytes.push_back(fcs[7:0] ^ {7'b0, inj});
        exp_bytes.push_back(fcs[15:8]);
        exp_bytes.push_back(fcs[23:16]);
        exp_bytes.push_back(fcs[31:24]);
        exp_len.push_back(lc + 8);
        exp_gap.push_back(first ? -1 : ic);
        exp_pkts   = exp_pkts + 64'd1;
        exp_octets = exp_octets + 64'(lc);
    endtask

    // ---------------- monitor ----------------
    logic [7:0] cap[$];
    bit         capturing = 1'b0;
    int         idle_cnt = 0;
    int         start_gap = 0;

    task automatic finish_frame();
        int         l, g, bad;
        logic [7:0] e;
        if (exp_len.size() == 0) begin
            chk("unexpected_frame_len", 64'(cap.size()), 64'd0);
        end else begin
            l   = exp_len.pop_front();
            g   = exp_gap.pop_front();
            bad = 0;
            for (int i = 0; i < l; i++) begin
                e = exp_bytes.pop_front();
                if (i >= cap.size() || cap[i] !== e) bad++;
            end
            chk("frame_octets", 64'(cap.size()), 64'(l));
            chk("frame_bad_bytes", 64'(bad), 64'd0);
            if (g >= 0) chk("ifg_idle_cycles", 64'(start_gap), 64'(g));
            chk("gmii_er", {63'd0, gif.gmii_er}, 64'd0);
        end
        cap.delete();
    endtask

    always @(negedge clk) begin
        if (reset) begin
            cap.delete();
            capturing = 1'b0;
            idle_cnt  = 0;
        end else if (gif.gmii_en) begin
            if (!capturing) begin
                capturing = 1'b1;
                start_gap = idle_cnt;
            end
            cap.push_back(gif.gmii_d);
        end else begin
            if (capturing) begin
                finish_frame();
                capturing = 1'b0;
                idle_cnt  = 0;
            end
            idle_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start_checked();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        chk("en_one_cycle_after_start", {63'd0, gif.gmii_en}, 64'd0);
        @(posedge clk); #1;
        chk("first_preamble_en", {63'd0, gif.gmii_en}, 64'd1);
        chk("first_preamble_d", {56'd0, gif.gmii_d}, 64'h55);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("busy_timeout", {63'd0, busy}, 64'd0);
    endtask

    task automatic end_checks();
        repeat (3) @(posedge clk);
        #1;
        chk("missing_frames", 64'(exp_len.size()), 64'd0);
        chk("pkts_sent", pkts_sent, exp_pkts);
        chk("octets_sent", octets_sent, exp_octets);
    endtask

    task automatic run_burst(input int len, input int ifg, input int fc, input bit inj, input bit scramble);
        bit inj_eff;
`ifdef GMII_FRAME_GENERATOR_CRC_ERR_INJECT_EN
        inj_eff = inj;
`else
        inj_eff = 1'b0;
`endif
        frame_len      = 16'(len);
        ifg_len        = 16'(ifg);
        frame_count    = 32'(fc);
        dst_mac        = cfg_dmac;
        src_mac        = cfg_smac;
        ethertype      = cfg_etype;
        payload_seed   = cfg_seed;
        inject_crc_err = inj;
        for (int f = 0; f < fc; f++) push_frame(len, ifg, f == 0, inj_eff);
        pulse_start_checked();
        if (scramble) begin
            frame_len    = 16'($urandom);
            ifg_len      = 16'($urandom);
            frame_count  = $urandom_range(1, 9);
            dst_mac      = {16'($urandom), 32'($urandom)};
            src_mac      = {16'($urandom), 32'($urandom)};
            ethertype    = 16'($urandom);
            payload_seed = 8'($urandom);
            repeat (15) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        wait_idle(fc * 1600 + 200);
        end_checks();
    endtask

    task automatic randomize_cfg();
        cfg_dmac  = {16'($urandom), 32'($urandom)};
        cfg_smac  = {16'($urandom), 32'($urandom)};
        cfg_etype = 16'($urandom);
        cfg_seed  = 8'($urandom);
    endtask

    initial begin
        int len;
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        frame_len = 16'd64; ifg_len = 16'd12; frame_count = 32'd1;
        dst_mac = '0; src_mac = '0; ethertype = '0; payload_seed = '0;
        inject_crc_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_en", {63'd0, gif.gmii_en}, 64'd0);
        chk("reset_d", {56'd0, gif.gmii_d}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_pkts", pkts_sent, 64'd0);
        chk("reset_octets", octets_sent, 64'd0);
        reset = 1'b0;

        // Reset asserted mid-DATA: the partial frame is never expected.
        randomize_cfg();
        frame_len = 16'd100; frame_count = 32'd2;
        dst_mac = cfg_dmac; src_mac = cfg_smac; ethertype = cfg_etype; payload_seed = cfg_seed;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (30) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("midframe_reset_en", {63'd0, gif.gmii_en}, 64'd0);
        chk("midframe_reset_busy", {63'd0, busy}, 64'd0);
        chk("midframe_reset_pkts", pkts_sent, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Basic three-frame burst.
        randomize_cfg();
        run_burst(64, 12, 3, 1'b0, 1'b0);

        // Known content frame.
        cfg_dmac = 48'hFFFF_FFFF_FFFF; cfg_smac = 48'h000A_3500_0001;
        cfg_etype = 16'h0800; cfg_seed = 8'hFE;
        run_burst(64, 12, 1, 1'b0, 1'b0);

        // Clamping.
        randomize_cfg();
        run_burst(10, 3, 1, 1'b0, 1'b0);
        randomize_cfg();
        run_burst(4000, 20, 1, 1'b0, 1'b0);

        // Random bursts with port changes and ignored start while busy.
        for (int r = 0; r < 4; r++) begin
            randomize_cfg();
            run_burst($urandom_range(0, 300), $urandom_range(0, 30), $urandom_range(1, 3), 1'b0, 1'b1);
        end

        // CRC error request held across a burst.
        randomize_cfg();
        run_burst(80, 14, 3, 1'b1, 1'b0);
        inject_crc_err = 1'b0;

        // Continuous mode stopped during the 5th frame's DATA.
        randomize_cfg();
        len = $urandom_range(64, 120);
        frame_len = 16'(len); ifg_len = 16'd12; frame_count = 32'd0;
        dst_mac = cfg_dmac; src_mac = cfg_smac; ethertype = cfg_etype; payload_seed = cfg_seed;
        for (int f = 0; f < 5; f++) push_frame(len, 12, f == 0, 1'b0);
        pulse_start_checked();
        begin
            int n = 0;
            while (pkts_sent != exp_pkts - 64'd1 && n < 5000) begin
                @(posedge clk);
                n++;
            end
            chk("continuous_reach_4", pkts_sent, exp_pkts - 64'd1);
        end
        repeat (25) @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        wait_idle(2000);
        end_checks();

        // Stop together with start in IDLE: nothing is sent.
        @(posedge clk); #1 start = 1'b1; stop = 1'b1;
        @(posedge clk); #1 start = 1'b0; stop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("start_stop_busy", {63'd0, busy}, 64'd0);
        chk("start_stop_en", {63'd0, gif.gmii_en}, 64'd0);

        // Stop alone in IDLE is ignored; next burst is normal.
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        randomize_cfg();
        run_burst(70, 12, 2, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gmii_frame_generator.md
Name: gmii_frame_generator

Overview:
- GMII transmit-side frame generator; the companion of the GMII traffic analyzer.
- Emits Ethernet frames on an 8-bit GMII TX interface: preamble, SFD, header, payload, FCS, then inter-frame gap.
- Frame content, length, gap and count come from control ports driven by the surrounding register block. Exposes running packet and octet counters.

Parameters:
C_MAX_FRAME_LEN, 1518, largest L2 frame length including FCS; longer requests are clamped to it.
C_COUNTER_WIDTH, 64, width of the pkts_sent and octets_sent counters.

Ports:
clk  input  1  single clock; all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  one-cycle pulse; latches configuration and begins a burst (ignored while busy).
stop  input  1  one-cycle pulse; current frame completes, then return to IDLE.
frame_len  input  16  L2 length including FCS, in octets.
ifg_len  input  16  idle octets after each FCS.
frame_count  input  32  frames per burst; 0 = continuous.
dst_mac  input  48  destination MAC, transmitted MSB octet first.
src_mac  input  48  source MAC, transmitted MSB octet first.
ethertype  input  16  transmitted MSB octet first.
payload_seed  input  8  first payload octet; each later payload octet = previous + 1 (mod 256).
inject_crc_err  input  1  see Optional Feature.
gmii_d  output  8  TX data.
gmii_en  output  1  TX enable.
gmii_er  output  1  TX error; always 0.
busy  output  1  high from the cycle after accepted start until return to IDLE.
pkts_sent  output  C_COUNTER_WIDTH  frames completed since reset.
octets_sent  output  C_COUNTER_WIDTH  L2 octets (incl. FCS, excl. preamble/SFD) since reset.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; CRC register 0xFFFFFFFF. Reset mid-frame drops gmii_en in the same edge-free manner (async), with no tail octets.
- Configuration latch: at accepted start, sample frame_len, ifg_len, frame_count, MACs, ethertype and payload_seed. Later port changes have no effect until the next start.
- Length clamping: frame_len < 64 uses 64; frame_len > C_MAX_FRAME_LEN uses C_MAX_FRAME_LEN. ifg_len < 12 uses 12.
- Registered outputs: first preamble octet appears on the 2nd clk after the start pulse.
- States and transitions:
  - IDLE: gmii_en=0, gmii_d=0. Accepted start -> PREAMBLE.
  - PREAMBLE: 7 octets of 0x55, en=1 -> SFD.
  - SFD: 0xD5; CRC register reset to 0xFFFFFFFF -> DATA.
  - DATA: L-4 octets in order: dst_mac, src_mac, ethertype, then incrementing payload. CRC updated per octet -> FCS.
  - FCS: 4 octets of ~crc, LSB octet first -> IFG.
  - IFG: en=0, d=0 for the clamped ifg_len cycles, then:
    - frames done == frame_count (nonzero) -> IDLE;
    - stop seen -> IDLE;
    - otherwise -> PREAMBLE.
- CRC: reflected CRC-32, polynomial 0xEDB88320, bytewise LSB-first update, init 0xFFFFFFFF.
- Counters: pkts_sent += 1 and octets_sent += L in the cycle of the last FCS octet. Both wrap at 2^C_COUNTER_WIDTH. They do not clear on start.
- stop:
  - In PREAMBLE..IFG: recorded; takes effect at end of IFG.
  - In IDLE: ignored.
  - Simultaneous with start while IDLE: stop wins, no frame sent.
- start while busy: ignored.
- frame_count=0: runs until stop or reset.
- Frame-number counter internal: 32 bits; compares to latched frame_count.

Optional Feature:
- Macro GMII_FRAME_GENERATOR_CRC_ERR_INJECT_EN.
- With macro: inject_crc_err is sampled at the start of each frame's PREAMBLE. When set, the first FCS octet is XORed with 0x01. The frame is still counted in pkts_sent/octets_sent.
- Without macro: inject_crc_err is ignored and FCS is always correct; the port remains present.

Test Plan:
- reset asserted mid-DATA -> gmii_en=0, busy=0, counters 0 immediately; next start transmits a normal frame.
- start, frame_len=64, ifg_len=12, frame_count=3 -> 3×(72 en-cycles: 7×0x55, 0xD5, 64 octets, then 12 idle); pkts_sent=3, octets_sent=192; busy falls after the third IFG.
- Frame content: dst=FF:FF:FF:FF:FF:FF, src=00:0A:35:00:00:01, ethertype=0x0800, seed=0xFE, len=64 -> payload 0xFE,0xFF,0x00,0x01…; FCS matches software CRC-32 model; loopback into the traffic analyzer gives crc_ok, pkts=1, octets=64.
- Clamping: frame_len=10, ifg_len=3 -> 64-octet frame with 12 idle cycles. frame_len=4000 -> 1518-octet frame.
- frame_count=0, stop pulsed during the 5th frame's DATA -> 5th frame completes with valid FCS plus IFG, then IDLE; pkts_sent=5.
- With macro: inject_crc_err=1 for frame 2 of 3 -> frame 2 first FCS octet differs from model by 0x01; analyzer reports bad_crc_pkts=1, pkts=2.
